core_writeback_arb: RTL

CORE_WRITEBACK_ARB -- requirements
Module: core_writeback_arb

---
 rtl/core_writeback_arb_pkg.sv | 21 ++
 rtl/core_writeback_arb_rr_pick.sv | 37 +++
 rtl/core_writeback_arb.sv | 81 ++++++++
 3 files changed

// File: rtl/core_writeback_arb_pkg.sv
// Shared types and default sizes for the core writeback arbiter.
// A wb_line is one register-file write request: valid bit, destination and data.
package core_writeback_arb_pkg;

  localparam int WB_NUM_PORTS = 2;
  localparam int WB_NUM_SRC   = 3;
  localparam int WB_ADDR_W    = 5;
  localparam int WB_DATA_W    = 32;

  typedef struct packed {
    logic                 ready;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_line;

  // Pointer width for n sources; a single source still gets one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/core_writeback_arb_rr_pick.sv
// Round-robin picker: grants the first eligible source at or after ptr.
// Sources already granted to a lower-indexed port are removed via mask.
module core_writeback_rr_pick
  import core_writeback_arb_pkg::*;
#(
  parameter int NUM_SRC = WB_NUM_SRC,
  parameter int PTR_W   = ptr_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic [NUM_SRC-1:0] mask,
  output logic [NUM_SRC-1:0] grant
);

  logic [NUM_SRC-1:0] elig;
  logic               found;
  int                 pos;

  assign elig = req & ~mask;

  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_SRC) pos = pos - NUM_SRC;
      for (int s = 0; s < NUM_SRC; s++) begin
        if (!found && elig[s] && (s == pos)) begin
          grant[s] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/core_writeback_arb.sv
// Register-file writeback arbiter: dedicated priority source per port, remaining
// ports shared round-robin among stallable sources, one-cycle registered output.
module core_writeback_arb
  import core_writeback_arb_pkg::*;
#(
  parameter int NUM_PORTS = WB_NUM_PORTS,
  parameter int NUM_SRC   = WB_NUM_SRC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  wb_line             wb_prio [NUM_PORTS],
  input  wb_line             wb_src  [NUM_SRC],
  output wb_line             wr      [NUM_PORTS],
  output logic [NUM_SRC-1:0] wb_stall
);

  localparam int PTR_W = ptr_width(NUM_SRC);

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   rr_ptr_d;
  logic [NUM_SRC-1:0] src_req;
  logic [NUM_SRC-1:0] granted;
  logic [NUM_SRC-1:0] mask       [NUM_PORTS+1];
  logic [NUM_SRC-1:0] pick       [NUM_PORTS];
  logic [NUM_SRC-1:0] port_grant [NUM_PORTS];
  wb_line             wr_d       [NUM_PORTS];

  always_comb begin
    src_req = '0;
    for (int s = 0; s < NUM_SRC; s++) src_req[s] = wb_src[s].ready;
  end

  // Each port sees the sources already taken by lower ports as masked.
  assign mask[0] = '0;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    core_writeback_rr_pick #(
      .NUM_SRC (NUM_SRC),
      .PTR_W   (PTR_W)
    ) u_pick (
      .req   (src_req),
      .ptr   (rr_ptr),
      .mask  (mask[p]),
      .grant (pick[p])
    );
    assign port_grant[p] = wb_prio[p].ready ? '0 : pick[p];
    assign mask[p+1]     = mask[p] | port_grant[p];
  end

  assign granted  = mask[NUM_PORTS];
  assign wb_stall = src_req & ~granted;

  // Higher ports overwrite rr_ptr_d, so it follows the last source granted.
  always_comb begin
    rr_ptr_d = rr_ptr;
    for (int p = 0; p < NUM_PORTS; p++) begin
      wr_d[p] = '0;
      if (wb_prio[p].ready) begin
        wr_d[p] = wb_prio[p];
      end else begin
        for (int s = 0; s < NUM_SRC; s++) begin
          if (port_grant[p][s]) begin
            wr_d[p]  = wb_src[s];
            rr_ptr_d = (s == NUM_SRC - 1) ? '0 : PTR_W'(s + 1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      for (int p = 0; p < NUM_PORTS; p++) wr[p] <= '0;
    end else begin
      rr_ptr <= rr_ptr_d;
      for (int p = 0; p < NUM_PORTS; p++) wr[p] <= wr_d[p];
    end
  end

endmodule
